// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: captures ALU output, decodes MEM strobes, checks alignment, drives EX->EX forward tap.
// Optional macro EX_MEM_PERF_CNT_EN adds saturating stall/bubble/misalign performance counters.
module ex_mem_pipe_reg #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [XLEN-1:0]      store_data,
    input  logic [XLEN-1:0]      pc_plus4,
    input  logic [RF_ADDR_W-1:0] rd_addr,
    input  logic [6:0]           opcode,
    input  logic [2:0]           func3,
    input  logic                 carry_flag,
    input  logic                 zero_flag,
    input  logic                 negative_flag,
    input  logic                 overflow_flag,
    output logic                 mem_valid,
    output logic [XLEN-1:0]      mem_alu_result,
    output logic [XLEN-1:0]      mem_store_data,
    output logic [XLEN-1:0]      mem_pc_plus4,
    output logic [RF_ADDR_W-1:0] mem_rd_addr,
    output logic [2:0]           mem_func3,
    output logic [3:0]           mem_flags,
    output logic                 mem_reg_write,
    output logic                 mem_mem_read,
    output logic                 mem_mem_write,
    output logic [1:0]           mem_wb_sel,
    output logic                 mem_misaligned,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_bubble_cnt,
    output logic [15:0]          perf_misalign_cnt,
`endif
    output logic                 fwd_valid,
    output logic [RF_ADDR_W-1:0] fwd_rd_addr,
    output logic [XLEN-1:0]      fwd_data
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      alu;
        logic [XLEN-1:0]      sdata;
        logic [XLEN-1:0]      pc4;
        logic [RF_ADDR_W-1:0] rd;
        logic [2:0]           f3;
        logic [3:0]           flags;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic [1:0]           wb_sel;
        logic                 misaligned;
    } ex_mem_t;

    ex_mem_t cur, nxt;

    logic is_load, is_store, is_alu, is_jump, is_mem, misalign;

    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_alu   = (opcode == OP_RTYPE) || (opcode == OP_IALU) ||
                   (opcode == OP_LUI)   || (opcode == OP_AUIPC);
        is_jump  = (opcode == OP_JAL)   || (opcode == OP_JALR);
        is_mem   = is_load || is_store;
    end

    // Size code 11 has no legal access in RV32, so it traps like a misaligned one.
    always_comb begin
        misalign = 1'b0;
        if (is_mem) begin
            case (func3[1:0])
                2'b01:   misalign = alu_result[0];
                2'b10:   misalign = (alu_result[1:0] != 2'b00);
                2'b11:   misalign = 1'b1;
                default: misalign = 1'b0;
            endcase
        end
    end

    // A non-valid EX slot decodes to an all-zero bubble.
    always_comb begin
        nxt = '0;
        if (ex_valid) begin
            nxt.valid      = 1'b1;
            nxt.alu        = alu_result;
            nxt.sdata      = store_data;
            nxt.pc4        = pc_plus4;
            nxt.rd         = rd_addr;
            nxt.f3         = func3;
            nxt.flags      = {carry_flag, zero_flag, negative_flag, overflow_flag};
            nxt.misaligned = misalign;
            nxt.mem_read   = is_load && !misalign;
            nxt.mem_write  = is_store && !misalign;
            nxt.reg_write  = (is_load || is_alu || is_jump) && !misalign &&
                             (rd_addr != '0);
            if (is_load)
                nxt.wb_sel = WB_MEM;
            else if (is_jump)
                nxt.wb_sel = WB_PC4;
            else
                nxt.wb_sel = WB_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cur <= '0;
        else if (flush)
            cur <= '0;
        else if (!stall)
            cur <= nxt;
    end

    always_comb begin
        mem_valid      = cur.valid;
        mem_alu_result = cur.alu;
        mem_store_data = cur.sdata;
        mem_pc_plus4   = cur.pc4;
        mem_rd_addr    = cur.rd;
        mem_func3      = cur.f3;
        mem_flags      = cur.flags;
        mem_reg_write  = cur.reg_write;
        mem_mem_read   = cur.mem_read;
        mem_mem_write  = cur.mem_write;
        mem_wb_sel     = cur.wb_sel;
        mem_misaligned = cur.misaligned;
    end

    // Load data only exists after MEM, so loads never feed the tap.
    always_comb begin
        fwd_valid   = cur.valid && cur.reg_write && (cur.wb_sel != WB_MEM);
        fwd_rd_addr = cur.rd;
        fwd_data    = (cur.wb_sel == WB_PC4) ? cur.pc4 : cur.alu;
    end

`ifdef EX_MEM_PERF_CNT_EN
    logic ev_stall, ev_bubble, ev_misalign;

    always_comb begin
        ev_stall    = stall && !flush;
        ev_bubble   = flush || (!stall && !ex_valid);
        ev_misalign = !flush && !stall && ex_valid && misalign;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt    <= '0;
            perf_bubble_cnt   <= '0;
            perf_misalign_cnt <= '0;
        end else begin
            if (ev_stall && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (ev_bubble && (perf_bubble_cnt != '1))
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (ev_misalign && (perf_misalign_cnt != '1))
                perf_misalign_cnt <= perf_misalign_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- EX/MEM pipeline register directly downstream of the execute-stage ALU.
- Captures the ALU result, its adder flags, store data, destination register and instruction identity each cycle.
- Derives registered MEM-stage control strobes from the captured opcode/func3 and checks load/store address alignment.
- Supports stall (hold) and flush (bubble) from hazard control, and drives an EX->EX forwarding tap.

Parameters:
- XLEN, 32, datapath width of result, store-data and PC fields.
- RF_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage holds a real instruction this cycle
- stall  in  1  hold all registered state
- flush  in  1  replace the captured instruction with a bubble
- alu_result  in  XLEN  ALU output (load/store effective address, or arithmetic result)
- store_data  in  XLEN  rs2 value for stores
- pc_plus4  in  XLEN  link value for JAL/JALR
- rd_addr  in  RF_ADDR_W  destination register
- opcode  in  7  instruction opcode
- func3  in  3  instruction func3
- carry_flag, zero_flag, negative_flag, overflow_flag  in  1 each  adder flags from the ALU
- mem_valid  out  1  MEM stage holds a real instruction
- mem_alu_result  out  XLEN  registered ALU result
- mem_store_data  out  XLEN  registered store data
- mem_pc_plus4  out  XLEN  registered link value
- mem_rd_addr  out  RF_ADDR_W  registered destination register
- mem_func3  out  3  registered func3 (access size and sign for memory)
- mem_flags  out  4  {carry, zero, negative, overflow}, registered
- mem_reg_write  out  1  write-back enable
- mem_mem_read  out  1  load strobe
- mem_mem_write  out  1  store strobe
- mem_wb_sel  out  2  write-back source: 00 = ALU, 01 = memory, 10 = pc_plus4
- mem_misaligned  out  1  captured load/store is misaligned
- fwd_valid  out  1  forwarding tap is usable
- fwd_rd_addr  out  RF_ADDR_W  forwarding destination register
- fwd_data  out  XLEN  forwarding data

Behaviour:
- Update priority per clock edge: rst > flush > stall > capture.
- Reset:
  - All outputs and internal registers are 0.
  - mem_wb_sel = 00.
  - Reset asserted mid-stall or mid-flush wins unconditionally.
- Flush:
  - mem_valid becomes 0 and all control strobes become 0.
  - Payload registers are cleared to 0.
  - flush and stall asserted together: flush wins.
- Stall (without flush): every register holds its value. Outputs are stable across any number of stall cycles.
- Capture with ex_valid = 0: identical to flush (bubble inserted).
- Capture with ex_valid = 1:
  - Payload and flags are registered.
  - mem_valid = 1.
  - Latency is exactly 1 cycle from EX inputs to mem_* outputs.
- Control decode is evaluated on the EX inputs and registered:
  - Load (0000011): mem_read = 1, wb_sel = 01, reg_write = 1.
  - Store (0100011): mem_write = 1, reg_write = 0.
  - R-type (0110011), I-ALU (0010011), LUI (0110111), AUIPC (0010111): reg_write = 1, wb_sel = 00.
  - JAL (1101111), JALR (1100111): reg_write = 1, wb_sel = 10.
  - Branch (1100011), SYSTEM, FENCE and all other opcodes: all strobes 0.
  - reg_write is forced to 0 when rd_addr = 0.
- Alignment check, applied to loads and stores only, using alu_result[1:0]:
  - Misaligned if func3[1:0] = 01 and bit0 = 1.
  - Misaligned if func3[1:0] = 10 and [1:0] != 00.
  - func3[1:0] = 11 is also flagged misaligned (illegal size).
  - When misaligned: mem_misaligned = 1, and mem_read, mem_write and reg_write are forced to 0.
  - mem_valid stays 1 so the trap logic sees the instruction.
- Forwarding tap (combinational from registered state):
  - fwd_valid = mem_valid & mem_reg_write & (mem_wb_sel != 01). Load data is not available in MEM.
  - fwd_data = pc_plus4 if wb_sel = 10, else alu_result.
  - fwd_rd_addr = mem_rd_addr.
- Invariant: no strobe or fwd_valid is ever 1 while mem_valid = 0.

Optional Feature:
- Macro: EX_MEM_PERF_CNT_EN.
- When defined, adds three outputs:
  - perf_stall_cnt (32): counts cycles with stall = 1 and flush = 0.
  - perf_bubble_cnt (32): counts edges that load a bubble (flush, or capture with ex_valid = 0).
  - perf_misalign_cnt (16): counts captured misaligned accesses.
- All three counters saturate at all-ones and clear on rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- rst = 1 for 2 cycles with ex_valid = 1, opcode = 0110011 -> all outputs 0 while reset is held and on the first cycle after release.
- ADD: alu_result = 0x0000_0005, rd = 3, ex_valid = 1 -> next cycle mem_valid = 1, reg_write = 1, wb_sel = 00, fwd_valid = 1, fwd_data = 0x5, fwd_rd_addr = 3.
- LW: alu_result = 0x1002, func3 = 010 -> mem_misaligned = 1, mem_read = 0, reg_write = 0, mem_valid = 1.
- LW: alu_result = 0x1004 -> mem_read = 1, wb_sel = 01, fwd_valid = 0.
- Capture JAL with pc_plus4 = 0x84, rd = 1; then stall = 1 for 3 cycles with changing inputs -> outputs hold fwd_data = 0x84 throughout.
- stall = 1 and flush = 1 together -> next cycle mem_valid = 0 and all strobes 0.
- Store with rd_addr = 0: mem_write = 1, reg_write = 0. ADDI with rd = 0: reg_write = 0, fwd_valid = 0.
- With EX_MEM_PERF_CNT_EN defined: 5 stall cycles + 2 flushes -> perf_stall_cnt = 5, perf_bubble_cnt = 2.
